pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RW, default 4: register-address width.
REQ-002 clk  in  1: single clock; all state updates on rising edge.
REQ-003 R  in  1: reset, asynchronous, active-high.
REQ-004 id_rn, id_rm  in  RW: source registers of the instruction in ID.
REQ-005 id_use_rn, id_use_rm  in  1: the matching ID source is actually read.
REQ-006 ex_rd, mem_rd, wb_rd  in  RW: destination registers in EX, MEM and WB.
REQ-007 ex_rf_le, mem_rf_le, wb_rf_le  in  1: the stage will write the register file.
REQ-008 ex_load  in  1: EX holds a load.
REQ-009 branch_taken  in  1: the branch in ID resolved taken.
REQ-010 mem_busy  in  1: data memory not ready; the whole pipe must hold.
REQ-011 pc_le, ifid_le  out  1: load enables for the PC and the IF/ID register.
REQ-012 ifid_clr  out  1: clears IF/ID to all-zero (drives IF/ID R).
REQ-013 idex_nop  out  1: inserts a bubble into ID/EX.
REQ-014 fwd_a, fwd_b  out  2: operand select for Rn and Rm; 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-015 state  out  2: FSM state, 00 RUN, 01 STALL, 10 MEMW.
REQ-016 stall_cnt  out  2: consecutive hazard-stall cycles, saturating at 3.

Function
REQ-017 Register 4'hF (PC) shall never match as a hazard or forward source.
REQ-018 A hazard source shall match only when its use bit is 1, the writer's rf_le is 1, and the addresses are equal.
REQ-019 Priority each cycle shall be mem_busy > hazard stall > branch flush > normal.
REQ-020 mem_busy=1 shall force pc_le=0, ifid_le=0, idex_nop=0, and next state MEMW; MEMW returns to RUN on the first cycle with mem_busy=0.
REQ-021 A hazard stall shall force pc_le=0, ifid_le=0, idex_nop=1, ifid_clr=0, next state STALL, and stall_cnt+1 saturating.
REQ-022 When no hazard is present, STALL shall return to RUN and stall_cnt shall clear to 0.
REQ-023 When branch_taken=1 with no stall and no mem_busy, the block shall assert ifid_clr=1 with pc_le=1 for exactly that cycle.
REQ-024 branch_taken during a stall or mem_busy shall be ignored; the ID source holds it until it is re-evaluated.
REQ-025 Normal operation shall drive pc_le=1, ifid_le=1, ifid_clr=0, idex_nop=0.
REQ-026 Forward selection shall use the youngest matching stage (EX over MEM over WB) and default to 00.
REQ-027 Forward selects and control outputs shall be combinational from inputs and state, with zero-cycle latency.

Reset
REQ-028 While R=1: state=RUN, stall_cnt=0, pc_le=0, ifid_le=0, ifid_clr=1, idex_nop=1, fwd_a=fwd_b=00.
REQ-029 R asserted mid-stall or in MEMW shall abort to RUN immediately; the first post-reset edge shall behave as RUN.

Configuration
REQ-030 Macro PIPE_FORWARD_EN defined: a hazard is only a load-use match (ex_load=1 with an EX match), giving a 1-cycle stall; forwarding per REQ-026 is enabled.
REQ-031 Macro PIPE_FORWARD_EN undefined: any EX, MEM or WB match is a hazard and stalls until it clears (up to 3 cycles); fwd_a and fwd_b are tied to 00.

Verification
REQ-032 R pulse mid-STALL with stall_cnt=2 -> state=00, stall_cnt=0, ifid_clr=1 while R=1; pc_le=1 the next cycle.
REQ-033 FORWARD_EN, ex_load=1, ex_rd=3, id_rn=3, use_rn=1 -> one cycle with pc_le=0, idex_nop=1; next cycle (match now in MEM) fwd_a=10, pc_le=1.
REQ-034 FORWARD_EN, ALU write ex_rd=5 and mem_rd=5, id_rm=5 -> fwd_b=01 with no stall; id_rm=15 with ex_rd=15 -> fwd_b=00.
REQ-035 No FORWARD_EN, ex_rd=2 match advancing through MEM and WB -> 3 stall cycles, stall_cnt 1,2,3, then RUN with stall_cnt=0.
REQ-036 mem_busy=1 for 4 cycles with branch_taken=1 and a hazard present -> state=MEMW and pc_le=0 throughout, no ifid_clr; then the hazard stall is taken, then the flush.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/hold control and operand forwarding.
// Optional PIPE_FORWARD_EN: forwarding on, only load-use hazards stall.
module pipe_hazard_ctrl #(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          R,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  input  logic [RW-1:0] ex_rd,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          ex_rf_le,
  input  logic          mem_rf_le,
  input  logic          wb_rf_le,
  input  logic          ex_load,
  input  logic          branch_taken,
  input  logic          mem_busy,
  output logic          pc_le,
  output logic          ifid_le,
  output logic          ifid_clr,
  output logic          idex_nop,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic [1:0]    state,
  output logic [1:0]    stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, MEMW = 2'b10} state_e;

  localparam logic [RW-1:0] PC_REG = '1;

  state_e     state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;

  // The PC register is never a real producer, so it never matches.
  function automatic logic hit(input logic [RW-1:0] src, input logic use_src,
                               input logic [RW-1:0] dst, input logic le);
    return use_src && le && (src == dst) && (src != PC_REG);
  endfunction

  logic rn_ex, rn_mem, rn_wb, rm_ex, rm_mem, rm_wb;
  logic load_use, hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign rn_ex  = hit(id_rn, id_use_rn, ex_rd,  ex_rf_le);
  assign rn_mem = hit(id_rn, id_use_rn, mem_rd, mem_rf_le);
  assign rn_wb  = hit(id_rn, id_use_rn, wb_rd,  wb_rf_le);
  assign rm_ex  = hit(id_rm, id_use_rm, ex_rd,  ex_rf_le);
  assign rm_mem = hit(id_rm, id_use_rm, mem_rd, mem_rf_le);
  assign rm_wb  = hit(id_rm, id_use_rm, wb_rd,  wb_rf_le);

  assign load_use = ex_load && (rn_ex || rm_ex);

`ifdef PIPE_FORWARD_EN
  assign hazard = load_use;
  // Youngest producer wins.
  assign fwd_a_raw = rn_ex ? 2'b01 : rn_mem ? 2'b10 : rn_wb ? 2'b11 : 2'b00;
  assign fwd_b_raw = rm_ex ? 2'b01 : rm_mem ? 2'b10 : rm_wb ? 2'b11 : 2'b00;
`else
  // Without bypass paths every in-flight producer must drain first.
  assign hazard = load_use || rn_ex || rn_mem || rn_wb || rm_ex || rm_mem || rm_wb;
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
`endif

  always_comb begin
    pc_le       = 1'b1;
    ifid_le     = 1'b1;
    ifid_clr    = 1'b0;
    idex_nop    = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    state_d     = RUN;
    stall_cnt_d = 2'd0;
    if (R) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      ifid_clr = 1'b1;
      idex_nop = 1'b1;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
    end else if (mem_busy) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      state_d     = MEMW;
      stall_cnt_d = stall_cnt_q;
    end else if (hazard) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      idex_nop    = 1'b1;
      state_d     = STALL;
      stall_cnt_d = (stall_cnt_q == 2'd3) ? 2'd3 : stall_cnt_q + 2'd1;
    end else if (branch_taken) begin
      ifid_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q     <= RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, R = 1'b0;
  logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic id_use_rn, id_use_rm, ex_rf_le, mem_rf_le, wb_rf_le, ex_load, branch_taken, mem_busy;
  logic pc_le, ifid_le, ifid_clr, idex_nop;
  logic [1:0] fwd_a, fwd_b, state, stall_cnt;
  int n_tests = 0, n_fail = 0;
  logic [11:0] obs;
  assign obs = {pc_le, ifid_le, ifid_clr, idex_nop, fwd_a, fwd_b, state, stall_cnt};

  pipe_hazard_ctrl #(.RW(4)) dut (
    .clk(clk), .R(R), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_le(ex_rf_le), .mem_rf_le(mem_rf_le),
    .wb_rf_le(wb_rf_le), .ex_load(ex_load), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_clr(ifid_clr), .idex_nop(idex_nop),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Inputs change 1ns after a rising edge; outputs are sampled 3ns later.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_rf_le = 0; mem_rf_le = 0; wb_rf_le = 0;
    ex_load = 0; branch_taken = 0; mem_busy = 0;
  endtask

  task automatic test_reset();
    idle(); id_rn = 4'd1; id_use_rn = 1; ex_rd = 4'd1; ex_rf_le = 1; branch_taken = 1;
    R = 1; #3;
    n_tests++;
    if (obs !== 12'b0011_00_00_00_00) begin n_fail++; $display("FAIL reset obs=%b exp=%b", obs, 12'b001100000000); end
    next_cycle(); R = 0; idle(); #3;
    n_tests++;
    if (obs !== 12'b1100_00_00_00_00) begin n_fail++; $display("FAIL post_reset_run obs=%b exp=%b", obs, 12'b110000000000); end
  endtask

  task automatic test_hazard_seq();
    logic [11:0] e;
    idle();
    if (FWD) begin
      ex_load = 1; ex_rd = 4'd3; ex_rf_le = 1; id_rn = 4'd3; id_use_rn = 1; #3;
      n_tests++;
      if (obs !== 12'b0001_01_00_00_00) begin n_fail++; $display("FAIL load_use_stall obs=%b exp=%b", obs, 12'b000101000000); end
      next_cycle(); ex_load = 0; ex_rf_le = 0; mem_rd = 4'd3; mem_rf_le = 1; #3;
      n_tests++;
      if (obs !== 12'b1100_10_00_01_01) begin n_fail++; $display("FAIL load_use_fwd_mem obs=%b exp=%b", obs, 12'b110010000101); end
    end else begin
      ex_rd = 4'd2; ex_rf_le = 1; id_rn = 4'd2; id_use_rn = 1;
      for (int c = 0; c < 3; c++) begin
        #3; e = {4'b0001, 4'b0000, (c == 0) ? 2'b00 : 2'b01, 2'(c)};
        n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL drain_stall%0d obs=%b exp=%b", c, obs, e); end
        next_cycle();
        ex_rf_le = 0; mem_rf_le = 0; wb_rf_le = 0;
        if (c == 0) begin mem_rd = 4'd2; mem_rf_le = 1; end
        if (c == 1) begin wb_rd = 4'd2; wb_rf_le = 1; end
      end
      #3;
      n_tests++;
      if (obs !== 12'b1100_0000_0111) begin n_fail++; $display("FAIL drain_release obs=%b exp=%b", obs, 12'b110000000111); end
    end
    next_cycle(); idle(); #3;
    n_tests++;
    if (obs !== 12'b1100_0000_0000) begin n_fail++; $display("FAIL back_to_run obs=%b exp=%b", obs, 12'b110000000000); end
  endtask

  task automatic test_forward();
    idle(); ex_rd = 4'd5; mem_rd = 4'd5; ex_rf_le = 1; mem_rf_le = 1; id_rm = 4'd5; id_use_rm = 1; #3;
    n_tests++;
    if (obs !== (FWD ? 12'b1100_00_01_00_00 : 12'b0001_00_00_00_00))
      begin n_fail++; $display("FAIL fwd_youngest obs=%b fwd=%0d", obs, FWD); end
    next_cycle(); idle(); next_cycle();
    ex_rd = 4'd15; ex_rf_le = 1; id_rm = 4'd15; id_use_rm = 1; mem_rd = 4'd5; mem_rf_le = 1; #3;
    n_tests++;
    if (obs !== 12'b1100_0000_0000) begin n_fail++; $display("FAIL pc_no_match obs=%b exp=%b", obs, 12'b110000000000); end
    next_cycle(); idle();
  endtask

  task automatic test_mem_busy();
    logic [11:0] e;
    idle(); ex_load = 1; ex_rd = 4'd6; ex_rf_le = 1; id_rm = 4'd6; id_use_rm = 1;
    branch_taken = 1; mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      #3; e = {4'b0000, FWD ? 2'b00 : 2'b00, FWD ? 2'b01 : 2'b00, (c == 0) ? 2'b00 : 2'b10, 2'b00};
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL mem_busy%0d obs=%b exp=%b", c, obs, e); end
      next_cycle();
    end
    mem_busy = 0; #3;
    e = {4'b0001, 2'b00, FWD ? 2'b01 : 2'b00, 2'b10, 2'b00};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL busy_then_stall obs=%b exp=%b", obs, e); end
    next_cycle(); ex_load = 0; ex_rf_le = 0; #3;
    n_tests++;
    if (obs !== 12'b1110_0000_0101) begin n_fail++; $display("FAIL then_flush obs=%b exp=%b", obs, 12'b111000000101); end
    next_cycle(); idle(); #3;
    n_tests++;
    if (obs !== 12'b1100_0000_0000) begin n_fail++; $display("FAIL flush_one_cycle obs=%b exp=%b", obs, 12'b110000000000); end
  endtask

  task automatic test_reset_mid_stall();
    idle(); ex_load = 1; ex_rd = 4'd4; ex_rf_le = 1; id_rn = 4'd4; id_use_rn = 1;
    next_cycle(); next_cycle(); #3;
    n_tests++;
    if (stall_cnt !== 2'd2 || state !== 2'b01) begin n_fail++; $display("FAIL pre_reset_cnt cnt=%0d state=%b exp=2/01", stall_cnt, state); end
    R = 1; #1;
    n_tests++;
    if (obs !== 12'b0011_0000_0000) begin n_fail++; $display("FAIL reset_mid_stall obs=%b exp=%b", obs, 12'b001100000000); end
    next_cycle(); R = 0; idle(); #3;
    n_tests++;
    if (pc_le !== 1'b1 || state !== 2'b00) begin n_fail++; $display("FAIL after_reset pc_le=%b state=%b exp=1/00", pc_le, state); end
    next_cycle();
  endtask

  function automatic bit mm(input int s, input bit u, input int d, input bit l);
    return u && l && s == d && s != 15;
  endfunction

  function automatic logic [3:0] raddr();
    int v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  task automatic test_random();
    int m_state = 0, m_cnt = 0;
    bit a_ex, a_mem, a_wb, b_ex, b_mem, b_wb, hz;
    int fa, fb, epc, eifid, eclr, enop;
    logic [11:0] e;
    for (int c = 0; c < 400; c++) begin
      R = ($urandom_range(0, 30) == 0);
      id_rn = raddr(); id_rm = raddr(); ex_rd = raddr(); mem_rd = raddr(); wb_rd = raddr();
      {id_use_rn, id_use_rm, ex_rf_le, mem_rf_le, wb_rf_le, ex_load} = 6'($urandom);
      branch_taken = ($urandom_range(0, 2) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      if (R) begin m_state = 0; m_cnt = 0; end
      a_ex = mm(id_rn, id_use_rn, ex_rd, ex_rf_le); b_ex = mm(id_rm, id_use_rm, ex_rd, ex_rf_le);
      a_mem = mm(id_rn, id_use_rn, mem_rd, mem_rf_le); b_mem = mm(id_rm, id_use_rm, mem_rd, mem_rf_le);
      a_wb = mm(id_rn, id_use_rn, wb_rd, wb_rf_le); b_wb = mm(id_rm, id_use_rm, wb_rd, wb_rf_le);
      hz = FWD ? (ex_load && (a_ex || b_ex)) : (a_ex || a_mem || a_wb || b_ex || b_mem || b_wb);
      fa = !FWD ? 0 : a_ex ? 1 : a_mem ? 2 : a_wb ? 3 : 0;
      fb = !FWD ? 0 : b_ex ? 1 : b_mem ? 2 : b_wb ? 3 : 0;
      if (R)             begin epc = 0; eifid = 0; eclr = 1; enop = 1; fa = 0; fb = 0; end
      else if (mem_busy) begin epc = 0; eifid = 0; eclr = 0; enop = 0; end
      else if (hz)       begin epc = 0; eifid = 0; eclr = 0; enop = 1; end
      else               begin epc = 1; eifid = 1; eclr = branch_taken; enop = 0; end
      e = {1'(epc), 1'(eifid), 1'(eclr), 1'(enop), 2'(fa), 2'(fb), 2'(m_state), 2'(m_cnt)};
      #3;
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL random%0d obs=%b exp=%b", c, obs, e); end
      next_cycle();
      if (R) begin m_state = 0; m_cnt = 0; end
      else if (mem_busy) m_state = 2;
      else if (hz) begin m_state = 1; m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3; end
      else begin m_state = 0; m_cnt = 0; end
    end
    R = 1; idle(); next_cycle(); R = 0;
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_hazard_seq();
    test_forward();
    test_mem_busy();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
